// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 16-bit pipelined CPU.
// Owns the PC, a RUN/HALTED state machine for HLT and a debug fetch counter.
module fetch_stage #(
   parameter int                 PC_W      = 16,
   parameter int                 INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
   parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallF,
   input  logic               stallD,
   input  logic               pcsrcD,
   input  logic [PC_W-1:0]    pcbranchD,
   input  logic               haltD,
   input  logic               resume_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instrD,
   output logic [PC_W-1:0]    pcplus1D,
   output logic               validD,
   output logic               halted_o,
   output logic [31:0]        fetch_count_o
);

   typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    w_pc_nxt;
   logic [PC_W-1:0]    w_pc_inc;
   logic [PC_W-1:0]    r_pcplus1;
   logic [PC_W-1:0]    w_pcplus1_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic [31:0]        r_count;
   logic [31:0]        w_count_nxt;
   logic               w_hold;

   // stallD together with pcsrcD is the hazard unit's branch signature, so it flushes rather than holds
   assign w_hold   = stallF | (stallD & ~pcsrcD);
   assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

   // Next-state and next-register values, ordered by priority: hold, branch, halt, fetch
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_pcplus1_nxt = r_pcplus1;
      w_instr_nxt   = r_instr;
      w_valid_nxt   = r_valid;
      w_count_nxt   = r_count;
      case (r_state)
         S_RUN: begin
            if (w_hold) begin
               w_state_nxt = S_RUN;
            end else if (pcsrcD) begin
               w_pc_nxt    = pcbranchD;
               w_instr_nxt = NOP_INSTR;
               w_valid_nxt = 1'b0;
            end else if (haltD && r_valid) begin
               w_state_nxt = S_HALTED;
               w_instr_nxt = NOP_INSTR;
               w_valid_nxt = 1'b0;
            end else begin
               w_pc_nxt      = w_pc_inc;
               w_pcplus1_nxt = w_pc_inc;
               w_instr_nxt   = instr_i;
               w_valid_nxt   = 1'b1;
               w_count_nxt   = r_count + 32'd1;
            end
         end
         S_HALTED: begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            if (resume_i) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_HALTED;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   // State, PC, IF/ID and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RUN;
         r_pc      <= RESET_PC;
         r_pcplus1 <= {PC_W{1'b0}};
         r_instr   <= NOP_INSTR;
         r_valid   <= 1'b0;
         r_count   <= 32'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pcplus1 <= w_pcplus1_nxt;
         r_instr   <= w_instr_nxt;
         r_valid   <= w_valid_nxt;
         r_count   <= w_count_nxt;
      end
   end

   assign pc_o          = r_pc;
   assign instrD        = r_instr;
   assign pcplus1D      = r_pcplus1;
   assign validD        = r_valid;
   assign halted_o      = (r_state == S_HALTED);
   assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID state per edge,
// a monitor pops and compares one time unit after each rising edge.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stallF, stallD, pcsrcD, haltD, resume_i;
   logic [15:0] pcbranchD;
   logic [15:0] instr_i;
   logic [15:0] pc_o, instrD, pcplus1D;
   logic        validD, halted_o;
   logic [31:0] fetch_count_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] pp1;
      logic        valid;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];

   // reference model state
   logic [15:0] m_pc, m_instr, m_pp1;
   logic        m_valid, m_halted;
   logic [31:0] m_cnt;

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stallF       (stallF),
      .stallD       (stallD),
      .pcsrcD       (pcsrcD),
      .pcbranchD    (pcbranchD),
      .haltD        (haltD),
      .resume_i     (resume_i),
      .instr_i      (instr_i),
      .pc_o         (pc_o),
      .instrD       (instrD),
      .pcplus1D     (pcplus1D),
      .validD       (validD),
      .halted_o     (halted_o),
      .fetch_count_o(fetch_count_o)
   );

   function automatic logic [15:0] mem(input logic [15:0] a);
      return 16'h1000 + a;
   endfunction

   assign instr_i = mem(pc_o);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
   endtask

   task automatic check_reset_values();
      chk("rst_pc", {16'h0, pc_o}, 32'h0);
      chk("rst_instr", {16'h0, instrD}, 32'h0);
      chk("rst_pp1", {16'h0, pcplus1D}, 32'h0);
      chk("rst_valid", {31'h0, validD}, 32'h0);
      chk("rst_halted", {31'h0, halted_o}, 32'h0);
      chk("rst_count", fetch_count_o, 32'h0);
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce
   task automatic step(input logic sf, input logic sd, input logic ps,
                       input logic [15:0] tgt, input logic hd, input logic rs);
      exp_t e;
      @(negedge clk);
      stallF = sf; stallD = sd; pcsrcD = ps; pcbranchD = tgt; haltD = hd; resume_i = rs;
      if (m_halted) begin
         if (rs) m_halted = 1'b0;
      end else if (sf || (sd && !ps)) begin
         m_halted = 1'b0;
      end else if (ps) begin
         m_pc = tgt; m_instr = 16'h0000; m_valid = 1'b0;
      end else if (hd && m_valid) begin
         m_halted = 1'b1; m_instr = 16'h0000; m_valid = 1'b0;
      end else begin
         m_instr = mem(m_pc);
         m_pc    = m_pc + 16'd1;
         m_pp1   = m_pc;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 32'd1;
      end
      e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1;
      e.valid = m_valid; e.halted = m_halted; e.cnt = m_cnt;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // Monitor: compare DUT outputs against queued expectations after every rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc_o", {16'h0, pc_o}, {16'h0, e.pc});
            chk("instrD", {16'h0, instrD}, {16'h0, e.instr});
            chk("pcplus1D", {16'h0, pcplus1D}, {16'h0, e.pp1});
            chk("validD", {31'h0, validD}, {31'h0, e.valid});
            chk("halted_o", {31'h0, halted_o}, {31'h0, e.halted});
            chk("fetch_count", fetch_count_o, e.cnt);
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0;
      stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0; haltD = 1'b0; resume_i = 1'b0;
      pcbranchD = 16'h0000;
      model_reset();
      #3;
      check_reset_values();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // sequential fetch, then a two-cycle stall at pc 5
      idle(5);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
      n = 0;
      while (m_pc != 16'd8 && n < 20) begin idle(1); n++; end
      chk("reach_pc8", {16'h0, m_pc}, 32'd8);

      // branch signature (stallD+pcsrcD), then stallF beating a branch
      step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b0);
      idle(1);

      // halt at pc 12, ignore hazard inputs while halted, then resume
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
              16'($urandom), $urandom_range(0, 1) == 1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      idle(3);

      // PC wrap from all-ones
      step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      idle(3);

      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, 16'($urandom),
              $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);

      // halt, then asynchronous reset while halted
      step(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
      idle(2);
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      idle(2);
      chk("model_halted", {31'h0, m_halted}, 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(4);

      @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
